cpu_bus_arbiter: RTL

- Shares the single CPU memory bus between the instruction-fetch requester (I port) and the data-memory requester (D port).
- Grants one requester at a time and registers its address, write data and write enable for the whole transaction.
- Holds `mem_start` until the memory unit signals `mem_done`, then routes `mem_q`/`mem_done` back to the owning requester only.
- Sits between the CPU fetch/memory stages and the memory unit. Data accesses are favoured, with a bounded-starvation guarantee for fetch.

---
 rtl/cpu_bus_arbiter_pkg.sv | 16 +
 rtl/bus_arb_priority.sv | 35 +++
 rtl/cpu_bus_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared encodings for the CPU memory-bus arbiter: FSM states, owner ids
// and the width of the data-port fairness streak counter.
package cpu_bus_arbiter_pkg;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_t;

  localparam logic BUS_OWN_I = 1'b0;
  localparam logic BUS_OWN_D = 1'b1;

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

endpackage

// File: rtl/bus_arb_priority.sv
// Fairness policy: D wins contested picks until it has won MAX_D_STREAK in a
// row, then I is forced through. Also produces the updated streak value.
module bus_arb_priority
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_req_i,
  input  logic                i_req_d,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant,
  output logic                o_owner,
  output logic [STREAK_W-1:0] o_streak_next
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  logic w_contested;
  logic w_force_i;

  always_comb begin
    w_contested   = i_req_i & i_req_d;
    w_force_i     = (i_streak == MAX_S);
    o_grant       = i_req_i | i_req_d;
    o_owner       = (i_req_d && !(w_contested && w_force_i)) ? BUS_OWN_D : BUS_OWN_I;
    o_streak_next = i_streak;
    // Uncontested D grants leave the streak untouched.
    if (o_grant && (o_owner == BUS_OWN_I)) begin
      o_streak_next = '0;
    end else if (w_contested && (i_streak != STREAK_SAT)) begin
      o_streak_next = i_streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU memory bus between fetch (I) and data (D) requesters.
// Handshake: a requester holds *_start high; its *_done pulses once, combinationally with mem_done.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         i_addr,
  input  logic [31:0]         i_data,
  input  logic                i_we,
  input  logic                i_start,
  output logic [31:0]         i_q,
  output logic                i_done,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_data,
  input  logic                d_we,
  input  logic                d_start,
  output logic [31:0]         d_q,
  output logic                d_done,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_data,
  output logic                mem_we,
  output logic                mem_start,
  input  logic [31:0]         mem_q,
  input  logic                mem_done,
  output logic                owner,
  output logic                busy,
  output logic                o_dbg_state,
  output logic [STREAK_W-1:0] o_dbg_streak
);

  bus_state_t          r_state;
  bus_state_t          w_state_next;
  logic                r_owner;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic                r_we;
  logic [STREAK_W-1:0] r_streak;

  logic                w_grant;
  logic                w_owner_pick;
  logic [STREAK_W-1:0] w_streak_next;
  logic                w_take;

  bus_arb_priority #(.MAX_D_STREAK(MAX_D_STREAK)) u_priority (
    .i_req_i       (i_start),
    .i_req_d       (d_start),
    .i_streak      (r_streak),
    .o_grant       (w_grant),
    .o_owner       (w_owner_pick),
    .o_streak_next (w_streak_next)
  );

  assign w_take = (r_state == BUS_IDLE) && w_grant;

  always_ff @(posedge clk) begin
    if (reset) r_state <= BUS_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUS_IDLE: if (w_grant)  w_state_next = BUS_BUSY;
      BUS_BUSY: if (mem_done) w_state_next = BUS_IDLE;
      default:                w_state_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == BUS_BUSY);
    mem_start = busy && !mem_done;
    i_done    = mem_done && busy && (r_owner == BUS_OWN_I);
    d_done    = mem_done && busy && (r_owner == BUS_OWN_D);
    i_q       = i_done ? mem_q : 32'd0;
    d_q       = d_done ? mem_q : 32'd0;
  end

  // Transaction fields are captured only at grant and held for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= BUS_OWN_I;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_streak <= '0;
    end else if (w_take) begin
      r_owner  <= w_owner_pick;
      r_streak <= w_streak_next;
      if (w_owner_pick == BUS_OWN_D) begin
        r_addr <= d_addr;
        r_data <= d_data;
        r_we   <= d_we;
      end else begin
        r_addr <= i_addr;
        r_data <= i_data;
        r_we   <= i_we;
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_data     = r_data;
  assign mem_we       = r_we;
  assign owner        = r_owner;
  assign o_dbg_state  = r_state;
  assign o_dbg_streak = r_streak;

endmodule
